perf_counter_bank: RTL and testbench

- Multi-channel event counter bank; the parametrised successor of the single edge-counting counter.
- Each channel counts pipeline/cache events in one of two modes: one count per rising edge of its event, or one count per cycle high.
- Adds per-channel clear, sticky overflow, wrap/saturate option, global freeze and a registered indexed read port.
- Sits beside the datapath/cache controllers; debug logic or a memory-mapped stats reader reads it.

---
 rtl/perf_pkg.sv | 19 +
 rtl/perf_counter_lane.sv | 56 +++++
 rtl/perf_counter_bank.sv | 71 +++++++
 tb/tb_perf_counter_bank.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and defaults for the performance counter bank.
// No logic; constants and the index-width helper only.
// No flow control.
package perf_pkg;

    typedef enum logic {
        PERF_LEVEL = 1'b0,
        PERF_EDGE  = 1'b1
    } perf_mode_e;

    localparam int PERF_WIDTH_DEFAULT  = 16;
    localparam int PERF_NUM_CH_DEFAULT = 8;

    // Index ports need at least one bit even for a single-channel bank.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/perf_counter_lane.sv
// One event counter channel: level/edge counting, clear, sticky overflow.
// Count updates on the edge after the qualifying event; no pipeline.
// No backpressure; freeze suppresses increments but still tracks the event.
module perf_counter_lane
    import perf_pkg::*;
#(
    parameter int WIDTH    = PERF_WIDTH_DEFAULT,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             evt,
    input  perf_mode_e       mode,
    input  logic             freeze,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    logic prev_evt;
    logic inc;
    logic at_max;

    assign inc    = ~freeze & ((mode == PERF_EDGE) ? (evt & ~prev_evt) : evt);
    assign at_max = &count;

    // Tracked even while frozen so an edge during freeze is consumed, not deferred.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_evt <= 1'b0;
        end else begin
            prev_evt <= evt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            if (!at_max) begin
                count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
            end else if (!SATURATE) begin
                count <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ovf <= 1'b0;
        end else if (inc && at_max) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with clear decode and a registered indexed read.
// Read port: one cycle from rd_idx to rd_count/rd_ovf; ovf vector is direct.
// No backpressure; events are sampled every cycle unless frozen.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int WIDTH    = PERF_WIDTH_DEFAULT,
    parameter int NUM_CH   = PERF_NUM_CH_DEFAULT,
    parameter bit SATURATE = 1'b0,
    parameter int IDX_W    = idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] event_in,
    input  logic [NUM_CH-1:0] edge_mode,
    input  logic              freeze,
    input  logic              clr,
    input  logic [IDX_W-1:0]  clr_idx,
    input  logic              clr_all,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WIDTH-1:0]  rd_count,
    output logic              rd_ovf,
    output logic [NUM_CH-1:0] ovf
);

    logic [WIDTH-1:0]  count_arr [NUM_CH];
    logic [NUM_CH-1:0] clr_hit;
    logic [WIDTH-1:0]  rd_count_nxt;
    logic              rd_ovf_nxt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        // Out-of-range clr_idx never matches any lane.
        assign clr_hit[i] = clr_all | (clr & (clr_idx == IDX_W'(i)));

        perf_counter_lane #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .evt    (event_in[i]),
            .mode   (perf_mode_e'(edge_mode[i])),
            .freeze (freeze),
            .clear  (clr_hit[i]),
            .count  (count_arr[i]),
            .ovf    (ovf[i])
        );
    end

    always_comb begin
        rd_count_nxt = '0;
        rd_ovf_nxt   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_count_nxt = count_arr[i];
                rd_ovf_nxt   = ovf[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= '0;
            rd_ovf   <= 1'b0;
        end else begin
            rd_count <= rd_count_nxt;
            rd_ovf   <= rd_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a wrapping and a saturating 4-bit,
// 6-channel instance share the same stimulus.
module tb_perf_counter_bank;

    localparam int W = 4;
    localparam int N = 6;
    localparam int IW = 3;

    logic          clk;
    logic          reset;
    logic [N-1:0]  event_in;
    logic [N-1:0]  edge_mode;
    logic          freeze;
    logic          clr;
    logic [IW-1:0] clr_idx;
    logic          clr_all;
    logic [IW-1:0] rd_idx;
    logic [W-1:0]  rd_count, s_rd_count;
    logic          rd_ovf, s_rd_ovf;
    logic [N-1:0]  ovf, s_ovf;

    int vectors = 0;
    int miscompares = 0;

    perf_counter_bank #(.WIDTH(W), .NUM_CH(N), .SATURATE(1'b0)) dut (
        .clk(clk), .reset(reset), .event_in(event_in), .edge_mode(edge_mode),
        .freeze(freeze), .clr(clr), .clr_idx(clr_idx), .clr_all(clr_all),
        .rd_idx(rd_idx), .rd_count(rd_count), .rd_ovf(rd_ovf), .ovf(ovf)
    );

    perf_counter_bank #(.WIDTH(W), .NUM_CH(N), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .event_in(event_in), .edge_mode(edge_mode),
        .freeze(freeze), .clr(clr), .clr_idx(clr_idx), .clr_all(clr_all),
        .rd_idx(rd_idx), .rd_count(s_rd_count), .rd_ovf(s_rd_ovf), .ovf(s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic rd(input int ch);
        rd_idx = IW'(ch);
        step();
    endtask

    task automatic clear_all();
        clr_all = 1'b1;
        step();
        clr_all = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; event_in = '0; edge_mode = '0; freeze = 1'b0;
        clr = 1'b0; clr_idx = '0; clr_all = 1'b0; rd_idx = '0;
        step(); step();
        reset = 1'b0;
        step();
        vectors++;
        if (rd_count !== 4'd0 || rd_ovf !== 1'b0 || ovf !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_wrap got count=%0d rovf=%0b ovf=%b want 0/0/000000", rd_count, rd_ovf, ovf);
        end
        vectors++;
        if (s_rd_count !== 4'd0 || s_rd_ovf !== 1'b0 || s_ovf !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_sat got count=%0d rovf=%0b ovf=%b want 0/0/000000", s_rd_count, s_rd_ovf, s_ovf);
        end
    endtask

    task automatic test_edge_level();
        edge_mode = 6'b000001;
        for (int c = 0; c < 9; c++) begin
            event_in[1:0] = (c != 5) ? 2'b11 : 2'b00;
            step();
        end
        event_in = '0;
        rd(0);
        vectors++;
        if (rd_count !== 4'd2 || s_rd_count !== 4'd2) begin
            miscompares++;
            $display("FAIL edge_ch0 got %0d/%0d want 2", rd_count, s_rd_count);
        end
        rd(1);
        vectors++;
        if (rd_count !== 4'd8 || s_rd_count !== 4'd8) begin
            miscompares++;
            $display("FAIL level_ch1 got %0d/%0d want 8", rd_count, s_rd_count);
        end
    endtask

    task automatic test_freeze();
        clear_all();
        edge_mode = 6'b000101;
        for (int c = 0; c < 9; c++) begin
            event_in[1:0] = (c != 5) ? 2'b11 : 2'b00;
            event_in[2]   = (c >= 2 && c <= 4);
            freeze        = (c == 2 || c == 3);
            step();
        end
        event_in = '0;
        freeze = 1'b0;
        rd(0);
        vectors++;
        if (rd_count !== 4'd2) begin
            miscompares++;
            $display("FAIL freeze_edge_ch0 got %0d want 2", rd_count);
        end
        rd(1);
        vectors++;
        if (rd_count !== 4'd6) begin
            miscompares++;
            $display("FAIL freeze_level_ch1 got %0d want 6", rd_count);
        end
        rd(2);
        vectors++;
        if (rd_count !== 4'd0) begin
            miscompares++;
            $display("FAIL freeze_lost_edge_ch2 got %0d want 0", rd_count);
        end
    endtask

    task automatic test_wrap_saturate();
        clear_all();
        edge_mode = '0;
        for (int c = 0; c < 16; c++) begin
            event_in = 6'b001000;
            step();
        end
        event_in = '0;
        rd(3);
        vectors++;
        if (rd_count !== 4'd0 || rd_ovf !== 1'b1 || ovf !== 6'b001000) begin
            miscompares++;
            $display("FAIL wrap16 got count=%0d rovf=%0b ovf=%b want 0/1/001000", rd_count, rd_ovf, ovf);
        end
        vectors++;
        if (s_rd_count !== 4'd15 || s_rd_ovf !== 1'b1 || s_ovf !== 6'b001000) begin
            miscompares++;
            $display("FAIL sat16 got count=%0d rovf=%0b ovf=%b want 15/1/001000", s_rd_count, s_rd_ovf, s_ovf);
        end
        for (int c = 0; c < 3; c++) begin
            event_in = 6'b001000;
            step();
        end
        event_in = '0;
        rd(3);
        vectors++;
        if (rd_count !== 4'd3 || rd_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_sticky got count=%0d rovf=%0b want 3/1", rd_count, rd_ovf);
        end
        vectors++;
        if (s_rd_count !== 4'd15 || s_rd_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_hold got count=%0d rovf=%0b want 15/1", s_rd_count, s_rd_ovf);
        end
    endtask

    task automatic test_clear();
        event_in = 6'b001000;
        clr = 1'b1;
        clr_idx = 3'd3;
        step();
        clr = 1'b0;
        event_in = '0;
        rd(3);
        vectors++;
        if (rd_count !== 4'd0 || rd_ovf !== 1'b0 || ovf !== 6'b0 ||
            s_rd_count !== 4'd0 || s_ovf !== 6'b0) begin
            miscompares++;
            $display("FAIL clr_beats_inc got %0d/%0b/%b sat %0d/%b want 0/0/000000", rd_count, rd_ovf, ovf, s_rd_count, s_ovf);
        end
        for (int c = 0; c < 7; c++) begin
            event_in[4] = (c < 3);
            event_in[5] = 1'b1;
            step();
        end
        event_in = '0;
        clr = 1'b1;
        clr_idx = 3'd6;
        step();
        clr = 1'b0;
        rd(4);
        vectors++;
        if (rd_count !== 4'd3) begin
            miscompares++;
            $display("FAIL clr_idx_oob_ch4 got %0d want 3", rd_count);
        end
        rd(5);
        vectors++;
        if (rd_count !== 4'd7) begin
            miscompares++;
            $display("FAIL clr_idx_oob_ch5 got %0d want 7", rd_count);
        end
        clear_all();
        rd(4);
        vectors++;
        if (rd_count !== 4'd0) begin
            miscompares++;
            $display("FAIL clr_all_ch4 got %0d want 0", rd_count);
        end
        rd(5);
        vectors++;
        if (rd_count !== 4'd0) begin
            miscompares++;
            $display("FAIL clr_all_ch5 got %0d want 0", rd_count);
        end
    endtask

    task automatic test_read_timing();
        for (int c = 0; c < 4; c++) begin
            event_in[4] = 1'b1;
            step();
        end
        event_in = '0;
        rd_idx = 3'd4;
        event_in[4] = 1'b1;
        step();
        event_in = '0;
        vectors++;
        if (rd_count !== 4'd4) begin
            miscompares++;
            $display("FAIL read_pre_update got %0d want 4", rd_count);
        end
        step();
        vectors++;
        if (rd_count !== 4'd5) begin
            miscompares++;
            $display("FAIL read_post_update got %0d want 5", rd_count);
        end
        rd(7);
        vectors++;
        if (rd_count !== 4'd0 || rd_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL read_oob got %0d/%0b want 0/0", rd_count, rd_ovf);
        end
    endtask

    task automatic test_reset_mid();
        clear_all();
        edge_mode = 6'b000001;
        for (int c = 0; c < 25; c++) begin
            event_in[0] = 1'b1;
            step();
            event_in[0] = 1'b0;
            step();
        end
        rd(0);
        vectors++;
        if (rd_count !== 4'd9 || rd_ovf !== 1'b1 || s_rd_count !== 4'd15 || s_rd_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset got %0d/%0b sat %0d/%0b want 9/1 sat 15/1", rd_count, rd_ovf, s_rd_count, s_rd_ovf);
        end
        event_in[0] = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (rd_count !== 4'd0 || rd_ovf !== 1'b0 || ovf !== 6'b0 || s_ovf !== 6'b0) begin
            miscompares++;
            $display("FAIL mid_reset got %0d/%0b/%b sat %b want 0/0/000000", rd_count, rd_ovf, ovf, s_ovf);
        end
        step();
        vectors++;
        if (rd_count !== 4'd0) begin
            miscompares++;
            $display("FAIL post_reset_read0 got %0d want 0", rd_count);
        end
        step();
        vectors++;
        if (rd_count !== 4'd1 || s_rd_count !== 4'd1) begin
            miscompares++;
            $display("FAIL post_reset_edge got %0d/%0d want 1", rd_count, s_rd_count);
        end
        event_in = '0;
    endtask

    initial begin
        test_reset();
        test_edge_level();
        test_freeze();
        test_wrap_saturate();
        test_clear();
        test_read_timing();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
